// File: rtl/alu_issue_queue_pkg.sv
// Shared defaults, FSM state type and opcode field constants for the ALU issue queue.
package alu_issue_queue_pkg;
    localparam int DEPTH_DEFAULT = 4;
    localparam int WIDTH_DEFAULT = 4;
    localparam int OPW_DEFAULT   = 3;
    localparam int SEQW_DEFAULT  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
endpackage

// File: rtl/alu_issue_queue_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is the entry at the read pointer.
module sync_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU operations, holds one stable in a registered issue slot and captures
// the combinational ALU result into a tagged valid/ready output slot.
//
// state | meaning
// IDLE  | issue slot empty, waiting for a FIFO entry
// EXEC  | issue slot drives the ALU, waiting for a free output slot to capture
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int OPW   = OPW_DEFAULT,
    parameter int SEQW  = SEQW_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPW-1:0]   in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_data_a,
    output logic [WIDTH-1:0] alu_data_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_status,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_status,
    output logic [SEQW-1:0]  out_seq,
    output logic             busy
);
    localparam int EW = OPW + 2 * WIDTH;

    state_t          state;
    state_t          state_nxt;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_head;
    logic            push;
    logic            pop;
    logic            capture;
    logic [EW-1:0]   issue_q;
    logic [SEQW-1:0] seq_cnt;

    // Reset is folded in so upstream never sees a ready while the block is held in reset.
    assign in_ready = reset && !fifo_full && !flush;
    assign push     = in_valid && in_ready;
    assign capture  = (state == EXEC) && !flush && (!out_valid || out_ready);

    sync_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_opcode, in_a, in_b}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = EXEC;
                    end
                end
                EXEC: begin
                    if (capture) begin
                        pop       = !fifo_empty;
                        state_nxt = fifo_empty ? IDLE : EXEC;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            issue_q <= '0;
        end else begin
            state <= state_nxt;
            if (flush)    issue_q <= '0;
            else if (pop) issue_q <= fifo_head;
        end
    end

    // A new capture wins over the consumer draining the slot on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_status <= '0;
            out_seq    <= '0;
            seq_cnt    <= '0;
        end else if (capture) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_status <= alu_status;
            out_seq    <= seq_cnt;
            seq_cnt    <= seq_cnt + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign alu_opcode = issue_q[EW-1 -: OPW];
    assign alu_data_a = issue_q[2*WIDTH-1 -: WIDTH];
    assign alu_data_b = issue_q[WIDTH-1:0];
    assign busy       = !fifo_empty || (state == EXEC) || out_valid;
endmodule
